spi_sck_engine: RTL and testbench
=================================

# spi_sck_engine

Parametrised SPI serial-clock engine for the SPI master datapath. It runs one complete frame per `start`: a programmable number of bits at a programmable SCK rate, in any of the four CPOL/CPHA modes. For every SCK edge it emits one-cycle `sample`/`shift` strobes for the shift register. It also sequences the frame with `busy`/`done` and supports abort via `enable`.

## Interface
Parameters:
- DIV_W, 8, width of `divider`; SCK half-period = divider+1 sysclk cycles
- CNT_W, 6, width of `nbits`; frame length = nbits+1 bits (1..2^CNT_W)
- CSD_W, 4, width of `cs_setup`/`cs_hold` (only with SPI_SCK_CSDLY_EN)

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  block enable; low aborts any frame
- start  in  1  frame request, accepted when enable=1 and busy=0
- cpol  in  1  SCK idle level
- cpha  in  1  0: sample on leading edge; 1: shift on leading edge
- divider  in  DIV_W  half-period minus one
- nbits  in  CNT_W  bits per frame minus one
- sck  out  1  serial clock
- sample  out  1  one-cycle strobe: capture MISO at this edge
- shift  out  1  one-cycle strobe: advance MOSI at this edge
- last  out  1  asserted together with the final `sample` strobe of a frame
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- cs_setup  in  CSD_W  (SPI_SCK_CSDLY_EN only) sysclk cycles between CS assert and RUN
- cs_hold  in  CSD_W  (SPI_SCK_CSDLY_EN only) sysclk cycles between the last edge and CS deassert
- cs_n  out  1  (SPI_SCK_CSDLY_EN only) active-low chip select

## Operation
- Reset values: sck=cpol input level, sampled continuously while idle; sample=shift=last=busy=done=0; cs_n=1; state IDLE.
- States: IDLE -> (SETUP) -> RUN -> (HOLD) -> IDLE. SETUP and HOLD exist only with the macro.
- Start accept: cpol, cpha, divider and nbits are latched into shadow registers. Later input changes have no effect until the next start.
- RUN:
  - Half-period counter loads `divider` and decrements each cycle.
  - At zero, sck toggles and the counter reloads.
  - A frame has exactly 2*(nbits+1) toggles, tracked by an edge counter of CNT_W+1 bits.
  - Leading edge = odd toggle (away from cpol); trailing edge = even toggle.
- Strobes:
  - cpha=0: `sample` on every leading edge. `shift` on every trailing edge except the final one.
  - cpha=1: `shift` on every leading edge, `sample` on every trailing edge.
  - Strobes are registered high in the same cycle sck takes its new value.
- Frame end: after the final toggle, sck equals the latched cpol. The state returns to IDLE (via HOLD if the macro is defined), with done=1 and busy=0 for one cycle.
- `start` while busy=1 is ignored. `start` in the `done` cycle is accepted (back-to-back frames).
- enable=0 at any time:
  - Next edge: state IDLE, sck=cpol, busy=0, cs_n=1, all strobes 0.
  - No `done` pulse.
  - start is ignored while enable=0.
- divider=0 gives sck toggling every sysclk cycle (sysclk/2) with correct strobes.

## Timing
- Start sampled at edge E: busy=1 after E. The first toggle occurs after edge E+divider+1 (no macro); each subsequent toggle follows divider+1 cycles later.
- The final toggle occurs at edge E+2*(nbits+1)*(divider+1). done=1/busy=0 after the next edge, lasting one cycle.
- Total start-to-done latency = 2*(nbits+1)*(divider+1)+1 cycles, plus cs_setup+cs_hold with the macro.
- `last` coincides with the final `sample` strobe: the final leading edge if cpha=0, the final toggle if cpha=1.

## Configuration
- SPI_SCK_CSDLY_EN defined:
  - cs_setup, cs_hold and cs_n ports exist.
  - cs_n falls at start accept; SETUP waits cs_setup cycles (0 = skip) before the RUN counter loads.
  - HOLD waits cs_hold cycles after the final toggle; cs_n rises in the same cycle done pulses.
- Undefined: no cs ports, no SETUP/HOLD states; chip select is owned by the parent.

## Test plan
- Mode 0, divider=1, nbits=7, start at E -> 16 toggles at E+2, E+4, ..., E+32. Eight `sample` strobes on rising edges, seven `shift` strobes. `last` at E+30; done at E+33; sck idles 0.
- Mode 3, divider=0, nbits=0 -> sck 1->0->1 at E+1 and E+2. `shift` at E+1, `sample`+`last` at E+2; done at E+3.
- Start repeated during a frame and again in the `done` cycle -> the first repeat is ignored; the second begins a new frame with no idle gap beyond the done cycle.
- Drop enable at mid-frame (after toggle 5 of 16) -> next edge: sck=cpol, busy=0, no done, no further strobes. A subsequent start runs a full frame.
- Change divider/cpol during a frame -> the current frame is unaffected; the new values apply at the next start.
- With SPI_SCK_CSDLY_EN, cs_setup=3, cs_hold=2, divider=0, nbits=0 -> cs_n low at E. Toggles at E+4 and E+5; cs_n high and done at E+8.

Source files
------------

// File: rtl/spi_sck_engine.sv
// SPI serial-clock engine: one frame of (nbits+1) bits per start, any CPOL/CPHA, per-edge strobes.
// Define SPI_SCK_CSDLY_EN to add chip-select generation with setup/hold delays.
module spi_sck_engine #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 6
`ifdef SPI_SCK_CSDLY_EN
   ,
   parameter int CSD_W = 4
`endif
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DIV_W-1:0] divider,
   input  logic [CNT_W-1:0] nbits,
`ifdef SPI_SCK_CSDLY_EN
   input  logic [CSD_W-1:0] cs_setup,
   input  logic [CSD_W-1:0] cs_hold,
   output logic             cs_n,
`endif
   output logic             sck,
   output logic             sample,
   output logic             shift,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int EW = CNT_W + 1;

`ifdef SPI_SCK_CSDLY_EN
   typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;
`else
   typedef enum logic {IDLE, RUN} state_t;
`endif

   state_t           state_q, state_d;
   logic             accept, load_run, tog, finish;
   logic             cpha_q, sck_q, fin_q;
   logic [DIV_W-1:0] div_q, hcnt_q;
   logic [EW-1:0]    ecnt_q;
`ifdef SPI_SCK_CSDLY_EN
   logic [CSD_W-1:0] csd_q, hold_q;
   logic             enter_hold;
`endif

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      load_run = 1'b0;
      tog      = 1'b0;
      finish   = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  accept = 1'b1;
`ifdef SPI_SCK_CSDLY_EN
                  if (cs_setup != '0) begin
                     state_d = SETUP;
                  end else begin
                     state_d  = RUN;
                     load_run = 1'b1;
                  end
`else
                  state_d  = RUN;
                  load_run = 1'b1;
`endif
               end
            end
`ifdef SPI_SCK_CSDLY_EN
            SETUP: begin
               if (csd_q == CSD_W'(1)) begin
                  state_d  = RUN;
                  load_run = 1'b1;
               end
            end
            HOLD: begin
               if (csd_q == CSD_W'(1)) begin
                  state_d = IDLE;
                  finish  = 1'b1;
               end
            end
`endif
            RUN: begin
               // fin_q marks the cycle after the final toggle
               if (fin_q) begin
`ifdef SPI_SCK_CSDLY_EN
                  if (hold_q != '0) begin
                     state_d = HOLD;
                  end else begin
                     state_d = IDLE;
                     finish  = 1'b1;
                  end
`else
                  state_d = IDLE;
                  finish  = 1'b1;
`endif
               end else if (hcnt_q == '0) begin
                  tog = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Shadow parameters and counters; the edge counter runs down from 2*(nbits+1)-1,
   // so an odd value marks a leading edge and zero marks the final toggle.
   always_ff @(posedge sysclk) begin
      if (accept) begin
         cpha_q <= cpha;
         div_q  <= divider;
         ecnt_q <= {nbits, 1'b1};
      end else if (tog) begin
         ecnt_q <= ecnt_q - EW'(1);
      end
      if (load_run)
         hcnt_q <= accept ? divider : div_q;
      else if (tog)
         hcnt_q <= div_q;
      else if (state_q == RUN)
         hcnt_q <= hcnt_q - DIV_W'(1);
   end

`ifdef SPI_SCK_CSDLY_EN
   assign enter_hold = (state_q == RUN) && fin_q && (state_d == HOLD);

   always_ff @(posedge sysclk) begin
      if (accept) begin
         csd_q  <= cs_setup;
         hold_q <= cs_hold;
      end else if (enter_hold) begin
         csd_q <= hold_q;
      end else if (state_q == SETUP || state_q == HOLD) begin
         csd_q <= csd_q - CSD_W'(1);
      end
   end
`endif

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sck_q   <= 1'b0;
         fin_q   <= 1'b0;
         sample  <= 1'b0;
         shift   <= 1'b0;
         last    <= 1'b0;
         done    <= 1'b0;
`ifdef SPI_SCK_CSDLY_EN
         cs_n    <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         done    <= finish;
         fin_q   <= tog && (ecnt_q == '0);
         sample  <= tog && (cpha_q ? !ecnt_q[0] : ecnt_q[0]);
         shift   <= tog && (cpha_q ? ecnt_q[0] : (!ecnt_q[0] && (ecnt_q != '0)));
         last    <= tog && (cpha_q ? (ecnt_q == '0) : (ecnt_q == EW'(1)));
         if (accept)
            sck_q <= cpol;
         else if (tog)
            sck_q <= ~sck_q;
`ifdef SPI_SCK_CSDLY_EN
         cs_n    <= (state_d == IDLE);
`endif
      end
   end

   // Idle SCK follows the cpol input; in the done cycle it still shows the frame's cpol
   assign sck  = (state_q == IDLE && !done) ? cpol : sck_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_sck_engine.sv
// Testbench for spi_sck_engine: formula-based frame model checked every cycle,
// plus directed frames with hand-computed event offsets.
module tb_spi_sck_engine;
   localparam int DIV_W = 8;
   localparam int CNT_W = 6;
`ifdef SPI_SCK_CSDLY_EN
   localparam int CSD_W = 4;
`endif

   logic             sysclk = 1'b0;
   logic             rst_n = 1'b0, enable = 1'b0, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [DIV_W-1:0] divider = '0;
   logic [CNT_W-1:0] nbits = '0;
   logic             sck, sample, shift, last, busy, done;
`ifdef SPI_SCK_CSDLY_EN
   logic [CSD_W-1:0] cs_setup = '0, cs_hold = '0;
   logic             cs_n;
`endif

   int n_checks = 0, n_pass = 0, cyc = 0;

   spi_sck_engine #(
      .DIV_W(DIV_W),
      .CNT_W(CNT_W)
`ifdef SPI_SCK_CSDLY_EN
      ,
      .CSD_W(CSD_W)
`endif
   ) dut (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .enable  (enable),
      .start   (start),
      .cpol    (cpol),
      .cpha    (cpha),
      .divider (divider),
      .nbits   (nbits),
`ifdef SPI_SCK_CSDLY_EN
      .cs_setup(cs_setup),
      .cs_hold (cs_hold),
      .cs_n    (cs_n),
`endif
      .sck     (sck),
      .sample  (sample),
      .shift   (shift),
      .last    (last),
      .busy    (busy),
      .done    (done)
   );

   always #5 sysclk = ~sysclk;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
   endtask

   // Frame model: toggle k lands at offset S + k*P from the accept edge, done at S+T*P+H+1
   bit m_act = 1'b0, m_done = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
   int m_e = 0, m_p = 1, m_t = 2, m_s = 0, m_h = 0;

   initial begin : scoreboard
      int   d, dd, k, m;
      logic e_sck, e_smp, e_shf, e_lst;
      forever begin
         @(posedge sysclk);
         cyc++;
         m_done = 1'b0;
         if (!rst_n || !enable) begin
            m_act = 1'b0;
         end else if (m_act) begin
            if (cyc - m_e == m_s + m_t * m_p + m_h + 1) begin
               m_act  = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            m_act  = 1'b1;
            m_e    = cyc;
            m_cpol = cpol;
            m_cpha = cpha;
            m_p    = int'(divider) + 1;
            m_t    = 2 * (int'(nbits) + 1);
`ifdef SPI_SCK_CSDLY_EN
            m_s    = int'(cs_setup);
            m_h    = int'(cs_hold);
`endif
         end
         @(negedge sysclk);
         if (!rst_n) begin
            m_act  = 1'b0;
            m_done = 1'b0;
         end
         e_smp = 1'b0;
         e_shf = 1'b0;
         e_lst = 1'b0;
         if (m_act) begin
            d  = cyc - m_e;
            dd = d - m_s;
            m  = (dd <= 0) ? 0 : ((dd / m_p > m_t) ? m_t : dd / m_p);
            e_sck = m_cpol ^ m[0];
            if (dd > 0 && dd % m_p == 0 && dd / m_p <= m_t) begin
               k = dd / m_p;
               if (m_cpha) begin
                  e_shf = k[0];
                  e_smp = !k[0];
                  e_lst = (k == m_t);
               end else begin
                  e_smp = k[0];
                  e_shf = !k[0] && (k != m_t);
                  e_lst = (k == m_t - 1);
               end
            end
         end else begin
            e_sck = m_done ? m_cpol : cpol;
         end
         check_bit("sck", sck, e_sck);
         check_bit("sample", sample, e_smp);
         check_bit("shift", shift, e_shf);
         check_bit("last", last, e_lst);
         check_bit("busy", busy, m_act);
         check_bit("done", done, m_done);
`ifdef SPI_SCK_CSDLY_EN
         check_bit("cs_n", cs_n, !m_act);
`endif
      end
   end

   int   ob_tog, ob_first_tog, ob_last_tog, ob_smp, ob_shf, ob_first_shf, ob_last, ob_done;
   logic ob_done_sck, ob_busy0, ob_cs0, ob_cs_done;

   // Drives start so it is sampled at edge E; params set with it
   task automatic launch(input logic pol, input logic pha, input int div, input int nb,
                         input bit hold_start);
      @(posedge sysclk); #2;
      cpol = pol;
      cpha = pha;
      divider = DIV_W'(div);
      nbits = CNT_W'(nb);
      start = 1'b1;
      @(posedge sysclk); #2;
      start = hold_start;
   endtask

   // Records event offsets d (outputs after edge E+d) until done or stop_tog toggles
   task automatic observe(input int budget, input int stop_tog);
      logic prev;
      ob_tog = 0; ob_first_tog = -1; ob_last_tog = -1; ob_smp = 0; ob_shf = 0;
      ob_first_shf = -1; ob_last = -1; ob_done = -1; ob_done_sck = 1'bx;
      ob_busy0 = 1'bx; ob_cs0 = 1'bx; ob_cs_done = 1'bx;
      prev = sck;
      for (int d = 0; d < budget; d++) begin
         @(negedge sysclk);
         if (d == 0) ob_busy0 = busy;
`ifdef SPI_SCK_CSDLY_EN
         if (d == 0) ob_cs0 = cs_n;
`endif
         if (sck !== prev) begin
            ob_tog++;
            if (ob_first_tog < 0) ob_first_tog = d;
            ob_last_tog = d;
         end
         prev = sck;
         if (sample) ob_smp++;
         if (shift) begin
            ob_shf++;
            if (ob_first_shf < 0) ob_first_shf = d;
         end
         if (last) ob_last = d;
         if (done) begin
            ob_done = d;
            ob_done_sck = sck;
`ifdef SPI_SCK_CSDLY_EN
            ob_cs_done = cs_n;
`endif
            break;
         end
         if (stop_tog != 0 && ob_tog == stop_tog) break;
      end
      if (stop_tog == 0 && ob_done < 0) begin
         n_checks++;
         $display("FAIL done_timeout cycle %0d: no done within %0d cycles", cyc, budget);
      end
   endtask

   initial begin : stim
      int seen;
      cpol = 1'b1;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      check_bit("rst_sck_cpol1", sck, 1'b1);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_sample", sample, 1'b0);
      #1 cpol = 1'b0;
      @(negedge sysclk);
      check_bit("rst_sck_cpol0", sck, 1'b0);
      @(posedge sysclk); #2;
      rst_n = 1'b1;
      enable = 1'b1;

      // Mode 0, divider 1, 8 bits
      launch(1'b0, 1'b0, 1, 7, 1'b0);
      observe(100, 0);
      check_int("m0_toggles", ob_tog, 16);
      check_int("m0_first_tog", ob_first_tog, 2);
      check_int("m0_last_tog", ob_last_tog, 32);
      check_int("m0_samples", ob_smp, 8);
      check_int("m0_shifts", ob_shf, 7);
      check_int("m0_last", ob_last, 30);
      check_int("m0_done", ob_done, 33);
      check_bit("m0_done_sck", ob_done_sck, 1'b0);

      // Mode 3, divider 0, 1 bit
      launch(1'b1, 1'b1, 0, 0, 1'b0);
      observe(20, 0);
      check_int("m3_toggles", ob_tog, 2);
      check_int("m3_first_tog", ob_first_tog, 1);
      check_int("m3_first_shift", ob_first_shf, 1);
      check_int("m3_samples", ob_smp, 1);
      check_int("m3_last", ob_last, 2);
      check_int("m3_done", ob_done, 3);

      // Start held through the frame and into the done cycle
      launch(1'b0, 1'b0, 1, 7, 1'b1);
      observe(100, 0);
      check_int("b2b_first_done", ob_done, 33);
      @(posedge sysclk); #2;
      start = 1'b0;
      observe(100, 0);
      check_bit("b2b_busy_no_gap", ob_busy0, 1'b1);
      check_int("b2b_second_done", ob_done, 33);

      // Abort after toggle 5 of 16
      launch(1'b0, 1'b0, 1, 7, 1'b0);
      observe(100, 5);
      check_int("abort_toggle5_at", ob_last_tog, 10);
      @(posedge sysclk); #2;
      enable = 1'b0;
      @(posedge sysclk);
      @(negedge sysclk);
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_sck", sck, 1'b0);
      seen = 0;
      repeat (6) begin
         @(negedge sysclk);
         if (done || sample || shift) seen++;
      end
      check_int("abort_quiet", seen, 0);
      @(posedge sysclk); #2;
      enable = 1'b1;
      launch(1'b0, 1'b0, 1, 7, 1'b0);
      observe(100, 0);
      check_int("abort_rerun_done", ob_done, 33);

      // Parameter changes mid-frame affect only the next frame
      launch(1'b0, 1'b0, 1, 3, 1'b0);
      cpol = 1'b1;
      divider = DIV_W'(3);
      observe(100, 0);
      check_int("chg_toggles", ob_tog, 8);
      check_int("chg_done", ob_done, 17);
      check_bit("chg_done_sck", ob_done_sck, 1'b0);
      @(negedge sysclk);
      check_bit("chg_idle_sck", sck, 1'b1);
      launch(1'b1, 1'b0, 3, 3, 1'b0);
      observe(100, 0);
      check_int("chg_next_first_tog", ob_first_tog, 4);
      check_int("chg_next_done", ob_done, 33);

      // Start ignored while disabled
      @(posedge sysclk); #2;
      enable = 1'b0;
      start = 1'b1;
      repeat (4) begin
         @(negedge sysclk);
         check_bit("dis_start_busy", busy, 1'b0);
      end
      @(posedge sysclk); #2;
      start = 1'b0;
      enable = 1'b1;

      // Longest frame: 64 bits at sysclk/2
      launch(1'b0, 1'b1, 0, 63, 1'b0);
      observe(300, 0);
      check_int("max_toggles", ob_tog, 128);
      check_int("max_samples", ob_smp, 64);
      check_int("max_last", ob_last, 128);
      check_int("max_done", ob_done, 129);

`ifdef SPI_SCK_CSDLY_EN
      cs_setup = 4'd3;
      cs_hold = 4'd2;
      launch(1'b0, 1'b0, 0, 0, 1'b0);
      observe(40, 0);
      check_bit("cs_low_at_start", ob_cs0, 1'b0);
      check_int("cs_first_tog", ob_first_tog, 4);
      check_int("cs_last_tog", ob_last_tog, 5);
      check_int("cs_done", ob_done, 8);
      check_bit("cs_high_at_done", ob_cs_done, 1'b1);
      cs_setup = '0;
      cs_hold = '0;
`endif

      // Random traffic, checked every cycle by the scoreboard
      for (int i = 0; i < 5000; i++) begin
         @(posedge sysclk); #2;
         start = ($urandom_range(0, 9) < 3);
         if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         if ($urandom_range(0, 11) == 0) begin
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            divider = DIV_W'($urandom_range(0, 3));
            nbits = ($urandom_range(0, 7) == 0) ? CNT_W'(63) : CNT_W'($urandom_range(0, 7));
`ifdef SPI_SCK_CSDLY_EN
            cs_setup = 4'($urandom_range(0, 3));
            cs_hold = 4'($urandom_range(0, 3));
`endif
         end
      end
      @(posedge sysclk); #2;
      start = 1'b0;
      enable = 1'b1;
      repeat (300) @(posedge sysclk);
      @(negedge sysclk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
